// File: rtl/prt_vtb_pkg.sv
// Shared types and helpers for the video-toolbox event-rate meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prt_vtb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    CAP  = 2'd3
  } state_t;

  // Gate counter must hold P_GATE-1; never let the width collapse to zero.
  function automatic int gate_w(input int gate);
    return (gate > 2) ? $clog2(gate) : 1;
  endfunction

endpackage

// File: rtl/prt_vtb_rate_ch.sv
// One event-rate channel: saturating accumulator, overflow bit, stability compare.
// Latency: results register on the CAP strobe and are visible the following cycle.
// Backpressure: none; every strobe in RUN is counted. Edge mode via PRT_VTB_RATE_EDGE_EN.
module prt_vtb_rate_ch #(
  parameter int P_CNT_W = 32,
  parameter int P_TOL   = 2
) (
  input  logic               SYS_CLK_IN,
  input  logic               SYS_RST_IN,
  input  logic               clr,
  input  logic               run,
  input  logic               cap,
  input  logic               prev_vld,
  input  logic               evt,
  output logic [P_CNT_W-1:0] rate,
  output logic               stable,
  output logic               ovf
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [P_CNT_W:0]   TOL     = (P_CNT_W+1)'(P_TOL);

  logic [P_CNT_W-1:0] acc_q;
  logic               acc_ovf_q;
  // rate_q doubles as the previous-window count: both update only on CAP
  // and both hold through aborts, so a separate copy would be identical.
  logic [P_CNT_W-1:0] rate_q;
  logic               ovf_q;
  logic               stable_q;
  logic               hit;
  logic [P_CNT_W:0]   diff;

`ifdef PRT_VTB_RATE_EDGE_EN
  logic evt_d_q;

  // Previous input sample, tracked in every state so a level already high
  // before RUN does not look like a fresh edge.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN) evt_d_q <= 1'b0;
    else             evt_d_q <= evt;
  end

  assign hit = evt & ~evt_d_q;
`else
  assign hit = evt;
`endif

  // Absolute difference between this window and the previous one.
  always_comb begin
    diff = '0;
    if (acc_q >= rate_q) diff = {1'b0, acc_q} - {1'b0, rate_q};
    else                 diff = {1'b0, rate_q} - {1'b0, acc_q};
  end

  // Saturating accumulator; an increment attempted at the ceiling flags overflow.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else if (clr) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
    end else if (run && hit) begin
      if (acc_q == CNT_MAX) acc_ovf_q <= 1'b1;
      else                  acc_q     <= acc_q + 1'b1;
    end
  end

  // Window capture; stability needs a valid, non-overflowed previous window.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN) begin
      rate_q   <= '0;
      ovf_q    <= 1'b0;
      stable_q <= 1'b0;
    end else if (cap) begin
      rate_q   <= acc_q;
      ovf_q    <= acc_ovf_q;
      stable_q <= prev_vld & ~acc_ovf_q & ~ovf_q & (diff <= TOL);
    end
  end

  assign rate   = rate_q;
  assign stable = stable_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/prt_vtb_rate.sv
// Multi-channel event-rate meter over a fixed gate window of P_GATE clocks.
// Latency: results and VLD_OUT appear P_GATE+2 cycles after entering CLR; period P_GATE+2.
// Backpressure: none; EN_IN low aborts to IDLE. Edge counting via PRT_VTB_RATE_EDGE_EN.
module prt_vtb_rate
  import prt_vtb_pkg::*;
#(
  parameter int P_GATE  = 125000000,
  parameter int P_CH    = 4,
  parameter int P_CNT_W = 32,
  parameter int P_TOL   = 2
) (
  input  logic                    SYS_CLK_IN,
  input  logic                    SYS_RST_IN,
  input  logic                    EN_IN,
  input  logic [P_CH-1:0]         EVT_IN,
  output logic [P_CH*P_CNT_W-1:0] RATE_OUT,
  output logic                    VLD_OUT,
  output logic [P_CH-1:0]         STABLE_OUT,
  output logic [P_CH-1:0]         OVF_OUT
);

  localparam int GW = gate_w(P_GATE);

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   gate_q;
  logic            prev_vld_q;
  logic            vld_q;
  logic            clr;
  logic            run;
  logic            cap;

  assign clr = (state_q == CLR);
  assign run = (state_q == RUN);
  assign cap = (state_q == CAP);

  // State register.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next state; enable loss in CLR/RUN abandons the window without a capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (EN_IN) state_d = CLR;
      CLR:     state_d = EN_IN ? RUN : IDLE;
      RUN: begin
        if (!EN_IN)            state_d = IDLE;
        else if (gate_q == '0) state_d = CAP;
      end
      CAP:     state_d = EN_IN ? CLR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gate counter: loaded in CLR, counts down to zero across the RUN cycles.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN)                gate_q <= '0;
    else if (clr)                   gate_q <= GW'(P_GATE - 1);
    else if (run && gate_q != '0)   gate_q <= gate_q - 1'b1;
  end

  // Previous-window validity: set by a capture, lost on any return to IDLE.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN)            prev_vld_q <= 1'b0;
    else if (state_d == IDLE)   prev_vld_q <= 1'b0;
    else if (cap)               prev_vld_q <= 1'b1;
  end

  // Result strobe lines up with the freshly captured channel registers.
  always_ff @(posedge SYS_CLK_IN or negedge SYS_RST_IN) begin
    if (!SYS_RST_IN) vld_q <= 1'b0;
    else             vld_q <= cap;
  end

  assign VLD_OUT = vld_q;

  for (genvar g = 0; g < P_CH; g++) begin : g_ch
    prt_vtb_rate_ch #(
      .P_CNT_W (P_CNT_W),
      .P_TOL   (P_TOL)
    ) u_ch (
      .SYS_CLK_IN (SYS_CLK_IN),
      .SYS_RST_IN (SYS_RST_IN),
      .clr        (clr),
      .run        (run),
      .cap        (cap),
      .prev_vld   (prev_vld_q),
      .evt        (EVT_IN[g]),
      .rate       (RATE_OUT[g*P_CNT_W +: P_CNT_W]),
      .stable     (STABLE_OUT[g]),
      .ovf        (OVF_OUT[g])
    );
  end

endmodule

// File: tb/tb_prt_vtb_rate.sv
// Directed bench: two meters (8-bit and 6-bit counters, gate 100) share stimulus.
// Latency: each window checked exactly 102 cycles after its CLR cycle.
// Backpressure: n/a.
module tb_prt_vtb_rate;

  localparam int M_NONE = 0;
  localparam int M_ALL  = 1;
  localparam int M_E4   = 2;
  localparam int M_E4P3 = 3;
  localparam int M_E4P2 = 4;
  localparam int M_ONE  = 5;
  localparam int M_F63  = 6;
  localparam int M_TOG  = 7;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  evt = 4'b0;
  logic [31:0] rate8;
  logic        vld8;
  logic [3:0]  stable8;
  logic [3:0]  ovf8;
  logic [23:0] rate6;
  logic        vld6;
  logic [3:0]  stable6;
  logic [3:0]  ovf6;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  prt_vtb_rate #(.P_GATE(100), .P_CH(4), .P_CNT_W(8), .P_TOL(2)) u_dut8 (
    .SYS_CLK_IN (sys_clk),
    .SYS_RST_IN (sys_rst_n),
    .EN_IN      (en),
    .EVT_IN     (evt),
    .RATE_OUT   (rate8),
    .VLD_OUT    (vld8),
    .STABLE_OUT (stable8),
    .OVF_OUT    (ovf8)
  );

  prt_vtb_rate #(.P_GATE(100), .P_CH(4), .P_CNT_W(6), .P_TOL(2)) u_dut6 (
    .SYS_CLK_IN (sys_clk),
    .SYS_RST_IN (sys_rst_n),
    .EN_IN      (en),
    .EVT_IN     (evt),
    .RATE_OUT   (rate6),
    .VLD_OUT    (vld6),
    .STABLE_OUT (stable6),
    .OVF_OUT    (ovf6)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pat(input int mode, input int i);
    case (mode)
      M_ALL:   return 1'b1;
      M_E4:    return (i % 4 == 0);
      M_E4P3:  return (i % 4 == 0) || (i >= 1 && i <= 3);
      M_E4P2:  return (i % 4 == 0) || i == 1 || i == 2;
      M_ONE:   return (i == 37);
      M_F63:   return (i < 63);
      M_TOG:   return (i % 2 == 1);
      default: return 1'b0;
    endcase
  endfunction

  // Entered in a CLR cycle with EN high; returns 102 cycles later (the VLD cycle).
  task automatic window(input string tag, input int m0, input int m1, input int m2, input int m3,
                        input logic [3:0] ign,
                        input logic [31:0] r8, input logic [3:0] s8, input logic [3:0] o8,
                        input logic [23:0] r6, input logic [3:0] s6, input logic [3:0] o6);
    evt = ign;
    tick();
    for (int i = 0; i < 100; i++) begin
      evt = {pat(m3, i), pat(m2, i), pat(m1, i), pat(m0, i)};
      if (i == 50) check({tag, ".vld_run"}, {31'b0, vld8}, 32'd0);
      tick();
    end
    evt = ign;
    check({tag, ".vld_cap"}, {31'b0, vld8}, 32'd0);
    tick();
    evt = 4'b0;
    check({tag, ".vld8"},    {31'b0, vld8}, 32'd1);
    check({tag, ".vld6"},    {31'b0, vld6}, 32'd1);
    check({tag, ".rate8"},   r8, r8 == r8 ? rate8 : 32'd0);
    check({tag, ".stable8"}, {28'b0, stable8}, {28'b0, s8});
    check({tag, ".ovf8"},    {28'b0, ovf8},    {28'b0, o8});
    check({tag, ".rate6"},   {8'b0, rate6},    {8'b0, r6});
    check({tag, ".stable6"}, {28'b0, stable6}, {28'b0, s6});
    check({tag, ".ovf6"},    {28'b0, ovf6},    {28'b0, o6});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_ok;
    #2 sys_rst_n = 1'b0;
    tick();
    tick();
    check("rst.rate8",   rate8, 32'd0);
    check("rst.vld8",    {31'b0, vld8}, 32'd0);
    check("rst.stable8", {28'b0, stable8}, 32'd0);
    check("rst.ovf8",    {28'b0, ovf8}, 32'd0);
    check("rst.rate6",   {8'b0, rate6}, 32'd0);
    sys_rst_n = 1'b1;
    tick();
    tick();
    en = 1'b1;
    tick();  // now in CLR

`ifndef PRT_VTB_RATE_EDGE_EN
    window("w1", M_ALL, M_E4, M_NONE, M_ONE, 4'hF,
           {8'd1, 8'd0, 8'd25, 8'd100}, 4'b0000, 4'b0000,
           {6'd1, 6'd0, 6'd25, 6'd63},  4'b0000, 4'b0001);
    window("w2", M_ALL, M_E4, M_NONE, M_ONE, 4'hF,
           {8'd1, 8'd0, 8'd25, 8'd100}, 4'b1111, 4'b0000,
           {6'd1, 6'd0, 6'd25, 6'd63},  4'b1110, 4'b0001);
    window("w3", M_ALL, M_E4P3, M_F63, M_ONE, 4'hF,
           {8'd1, 8'd63, 8'd28, 8'd100}, 4'b1001, 4'b0000,
           {6'd1, 6'd63, 6'd28, 6'd63},  4'b1000, 4'b0001);
    window("w4", M_NONE, M_E4P2, M_F63, M_ONE, 4'hF,
           {8'd1, 8'd63, 8'd27, 8'd0}, 4'b1110, 4'b0000,
           {6'd1, 6'd63, 6'd27, 6'd0}, 4'b1110, 4'b0000);
    en = 1'b0;   // drop enable during CLR
    tick();
    check("clr_abort.vld_pulse", {31'b0, vld8}, 32'd0);
    check("clr_abort.hold",      rate8, {8'd1, 8'd63, 8'd27, 8'd0});
    repeat (3) tick();
    en = 1'b1;
    tick();
`endif

    window("wa", M_NONE, M_TOG, M_ONE, M_NONE, 4'h0,
           {8'd0, 8'd1, 8'd50, 8'd0}, 4'b0000, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd0}, 4'b0000, 4'b0000);
    window("wb", M_NONE, M_TOG, M_ONE, M_NONE, 4'h0,
           {8'd0, 8'd1, 8'd50, 8'd0}, 4'b1111, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd0}, 4'b1111, 4'b0000);

    // Abort at RUN cycle 50.
    evt = 4'b0;
    tick();
    for (int i = 0; i < 50; i++) begin
      evt = {pat(M_NONE, i), pat(M_ONE, i), pat(M_TOG, i), pat(M_NONE, i)};
      tick();
    end
    en = 1'b0;
    tick();
    hold_ok = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (vld8 !== 1'b0 || vld6 !== 1'b0) hold_ok = 1'b0;
      tick();
    end
    check("run_abort.no_vld",  {31'b0, hold_ok}, 32'd1);
    check("run_abort.rate8",   rate8, {8'd0, 8'd1, 8'd50, 8'd0});
    check("run_abort.stable8", {28'b0, stable8}, 32'hF);
    en = 1'b1;
    tick();
    window("wc", M_NONE, M_TOG, M_ONE, M_NONE, 4'h0,
           {8'd0, 8'd1, 8'd50, 8'd0}, 4'b0000, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd0}, 4'b0000, 4'b0000);

    // Asynchronous reset in the middle of RUN, between clock edges.
    evt = 4'b0;
    tick();
    repeat (30) tick();
    #3 sys_rst_n = 1'b0;
    #1;
    check("arst.rate8",   rate8, 32'd0);
    check("arst.rate6",   {8'b0, rate6}, 32'd0);
    check("arst.stable8", {28'b0, stable8}, 32'd0);
    check("arst.vld8",    {31'b0, vld8}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    evt = 4'b0001;  // ch0 high from before CLR
    tick();         // IDLE -> CLR

`ifdef PRT_VTB_RATE_EDGE_EN
    window("we", M_ALL, M_TOG, M_ONE, M_NONE, 4'h1,
           {8'd0, 8'd1, 8'd50, 8'd0}, 4'b0000, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd0}, 4'b0000, 4'b0000);
    window("wf", M_ALL, M_TOG, M_ONE, M_NONE, 4'h1,
           {8'd0, 8'd1, 8'd50, 8'd0}, 4'b1111, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd0}, 4'b1111, 4'b0000);
`else
    window("we", M_ALL, M_TOG, M_ONE, M_NONE, 4'h1,
           {8'd0, 8'd1, 8'd50, 8'd100}, 4'b0000, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd63},  4'b0000, 4'b0001);
    window("wf", M_ALL, M_TOG, M_ONE, M_NONE, 4'h1,
           {8'd0, 8'd1, 8'd50, 8'd100}, 4'b1111, 4'b0000,
           {6'd0, 6'd1, 6'd50, 6'd63},  4'b1110, 4'b0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prt_vtb_rate.md
Name: prt_vtb_rate

Overview:
Multi-channel event-rate meter for the video toolbox. It counts per-cycle strobes on P_CH independent event inputs (pixel enables, line/frame strobes, lock pulses) over a fixed gate window of P_GATE system clocks. It publishes per-channel counts, stability and overflow flags.
Single clock domain. Event inputs must already be synchronous to SYS_CLK_IN; upstream CDC is the caller's responsibility.

Parameters:
P_GATE, 125000000, gate window length in SYS_CLK_IN cycles (≥2); counts per window equal events per second when P_GATE equals the system frequency
P_CH, 4, number of event channels (1..16)
P_CNT_W, 32, per-channel counter/result width (4..32)
P_TOL, 2, maximum |new−previous| difference for a channel to be flagged stable

Ports:
SYS_CLK_IN  input  1  system clock
SYS_RST_IN  input  1  reset, asynchronous assert, active-low
EN_IN  input  1  measurement enable; low aborts and idles
EVT_IN  input  P_CH  event strobes, bit n = channel n
RATE_OUT  output  P_CH*P_CNT_W  last captured counts, channel n at bits [n*P_CNT_W +: P_CNT_W]
VLD_OUT  output  1  one-cycle pulse when RATE_OUT/STABLE_OUT/OVF_OUT update
STABLE_OUT  output  P_CH  channel count within P_TOL of previous window
OVF_OUT  output  P_CH  channel counter saturated in last window

Behaviour:
- Reset (SYS_RST_IN low): state IDLE. RATE_OUT, VLD_OUT, STABLE_OUT, OVF_OUT, accumulators, previous-count registers, gate counter and first-window flag all 0. Takes effect immediately; any window in progress is discarded.
- State machine:
  - IDLE: wait for EN_IN=1, then go to CLR.
  - CLR (1 cycle): zero accumulators and overflow bits; load gate counter with P_GATE−1; go to RUN.
  - RUN: each cycle, sample EVT_IN into the accumulators; decrement the gate counter. On the cycle the counter is 0 (that cycle is still counted), go to CAP. RUN therefore lasts exactly P_GATE cycles.
  - CAP (1 cycle): register accumulators into RATE_OUT, set OVF_OUT, compute STABLE_OUT, copy counts into previous-count registers. Next state is CLR if EN_IN=1, otherwise IDLE.
- VLD_OUT is high for exactly the cycle after CAP, coinciding with the new output values. Window period is P_GATE+2 cycles.
- Events on EVT_IN during IDLE, CLR and CAP are ignored.
- Accumulator: increments by 1 per counted event and saturates at 2^P_CNT_W−1. Any attempted increment past the maximum sets that channel's overflow bit for the window. A window reaching exactly the maximum without a further event has overflow = 0.
- Stability:
  - Compute |new−prev| in P_CNT_W+1 bits, unsigned compare ≤ P_TOL.
  - Forced 0 on the first capture after reset or after any return to IDLE, since there is no valid previous value.
  - Forced 0 if the channel overflowed in either the current or the previous window.
- EN_IN low during CLR or RUN: abort to IDLE next cycle, no CAP, no VLD_OUT. Outputs hold their last values; the first-window flag is cleared.
- EN_IN is sampled in CAP only for the next-state decision; the capture itself always completes.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
PRT_VTB_RATE_EDGE_EN
- Defined: each channel counts rising edges of EVT_IN. A registered copy of EVT_IN is kept; the previous-sample register updates every cycle in all states and resets to 0. An input held high for the whole window counts 1 if it rose inside RUN, else 0.
- Undefined: each channel counts cycles where EVT_IN is high (clock-enable counting); no edge register is instantiated.

Decomposition:
- Package prt_vtb_pkg: state enum (IDLE, CLR, RUN, CAP) and the gate-counter width function ($clog2(P_GATE)).
- One sub-module, prt_vtb_rate_ch, instantiated P_CH times via generate. It holds the saturating accumulator, overflow bit, previous-count register, stability compare and the optional edge detector. It is driven by the top-level clr/run/cap strobes and first-window flag.
- The top level holds the FSM, gate counter and output packing.

Test Plan:
1. P_GATE=100, EN_IN=1; ch0 strobe every cycle, ch1 every 4th cycle, ch2 idle, ch3 one pulse → VLD_OUT after 102 cycles; RATE_OUT = 100, 25, 0, 1; STABLE_OUT=0000 (first window).
2. Same stimulus for a second window → identical counts, STABLE_OUT=1111. Third window with ch1 at 28 (P_TOL=2) → ch1 stable=0, others 1.
3. P_CNT_W=6, P_GATE=100, ch0 constant high → RATE_OUT ch0 = 63, OVF_OUT[0]=1, STABLE_OUT[0]=0 in the next window too.
4. Drop EN_IN at RUN cycle 50 → no VLD_OUT, outputs hold. Re-enable → the next capture after a full window has STABLE_OUT=0.
5. Assert SYS_RST_IN low mid-RUN, asynchronously between clock edges → all outputs 0 immediately. After release with EN_IN=1, the first VLD_OUT arrives 102 cycles after the first CLR.
6. PRT_VTB_RATE_EDGE_EN defined; ch0 held high from before CLR, ch1 toggles every cycle → ch0 = 0, ch1 = 50.
